// File: rtl/sparse_token_pkg.sv
// Shared definitions for the 17-bit sparse ready/valid token stream.
package sparse_token_pkg;

  localparam int unsigned TOKEN_W = 17;

  typedef logic [TOKEN_W-1:0] token_t;

  // Control tokens carry bit16=1; DONE is {1, 8'h01, 8'h00}, STOP(L) is {1, 8'h00, L}
  localparam token_t DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sink_state_e;

  function automatic logic is_done(input token_t t);
    return t == DONE_TOKEN;
  endfunction

  function automatic logic is_stop(input token_t t);
    return t[16] && (t[15:8] == 8'h00);
  endfunction

  function automatic logic [7:0] stop_lvl(input token_t t);
    return t[7:0];
  endfunction

endpackage

// File: rtl/stream_token_sink_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) used for reproducible backpressure.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next state: shift right, fold the feedback polynomial in when the LSB falls out
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  // State register, reseeded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/stream_token_sink.sv
// Sparse token stream sink: checks accepted tokens against a preloaded expected RAM
// and reports done / first mismatch / overflow / token and cycle counts.
// Optional macro STREAM_SINK_STALL_EN adds LFSR-driven pseudo-random backpressure.
module stream_token_sink
  import sparse_token_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] STALL_MASK = 16'h0003,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               flush,
  input  logic               tile_en,
  input  logic               start,
  input  logic               exp_wr_en,
  input  logic [AW-1:0]      exp_wr_addr,
  input  logic [TOKEN_W-1:0] exp_wr_data,
  input  logic [TOKEN_W-1:0] data_in,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  output logic               done,
  output logic               mismatch,
  output logic [AW-1:0]      mismatch_idx,
  output logic               overflow,
  output logic [AW:0]        token_count,
  output logic [31:0]        cycle_count
);

  sink_state_e   state_q, state_d;
  logic          done_q, done_d;
  logic          mismatch_q, mismatch_d;
  logic [AW-1:0] mismatch_idx_q, mismatch_idx_d;
  logic          overflow_q, overflow_d;
  logic [AW:0]   token_count_q, token_count_d;
  logic [31:0]   cycle_count_q, cycle_count_d;
  logic          armed_q, armed_d;

  logic          stall_ok_c;
  logic          xfer_c;
  logic          ram_we_c;
  token_t        exp_tok_c;
  logic          clr_c;

  token_t        ram_q [DEPTH];

`ifdef STREAM_SINK_STALL_EN
  logic [15:0] lfsr_state;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en && (state_q == ST_RUN)),
    .state (lfsr_state)
  );

  assign stall_ok_c = (lfsr_state & STALL_MASK) != 16'h0000;
`else
  logic [31:0] unused_stall_params_c;

  assign unused_stall_params_c = {LFSR_SEED, STALL_MASK};
  assign stall_ok_c            = 1'b1;
`endif

  // Ready depends only on state, enables and the LFSR, never on valid
  assign data_in_ready = clk_en && tile_en && (state_q == ST_RUN) && stall_ok_c;
  assign xfer_c        = data_in_valid && data_in_ready;
  assign exp_tok_c     = ram_q[token_count_q[AW-1:0]];
  assign ram_we_c      = clk_en && exp_wr_en && (state_q == ST_IDLE);

  // Expected-token RAM: writable only while idle, contents survive reset and flush
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram_q[exp_wr_addr] <= exp_wr_data;
    end
  end

  // Next-state, compare and counter logic
  always_comb begin
    state_d        = state_q;
    done_d         = done_q;
    mismatch_d     = mismatch_q;
    mismatch_idx_d = mismatch_idx_q;
    overflow_d     = overflow_q;
    token_count_d  = token_count_q;
    cycle_count_d  = cycle_count_q;
    armed_d        = armed_q;
    clr_c          = 1'b0;

    if (clk_en) begin
      if (flush) begin
        state_d = ST_IDLE;
        clr_c   = 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start && tile_en) begin
              state_d = ST_RUN;
              clr_c   = 1'b1;
            end
          end
          ST_RUN: begin
            // The arming cycle itself is counted so the window is inclusive
            if (data_in_valid) begin
              armed_d = 1'b1;
            end
            if ((armed_q || data_in_valid) && (cycle_count_q != 32'hFFFF_FFFF)) begin
              cycle_count_d = cycle_count_q + 32'd1;
            end
            if (xfer_c) begin
              token_count_d = token_count_q + (AW+1)'(1);
              if ((data_in != exp_tok_c) && !mismatch_q) begin
                mismatch_d     = 1'b1;
                mismatch_idx_d = token_count_q[AW-1:0];
              end
              if (is_done(data_in)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else if (token_count_q == (AW+1)'(DEPTH - 1)) begin
                state_d    = ST_DONE;
                done_d     = 1'b1;
                overflow_d = 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (start) begin
              state_d = ST_RUN;
              clr_c   = 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            clr_c   = 1'b1;
          end
        endcase
      end
    end

    if (clr_c) begin
      done_d         = 1'b0;
      mismatch_d     = 1'b0;
      mismatch_idx_d = '0;
      overflow_d     = 1'b0;
      token_count_d  = '0;
      cycle_count_d  = '0;
      armed_d        = 1'b0;
    end
  end

  // Run-state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      done_q         <= 1'b0;
      mismatch_q     <= 1'b0;
      mismatch_idx_q <= '0;
      overflow_q     <= 1'b0;
      token_count_q  <= '0;
      cycle_count_q  <= '0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_q         <= done_d;
      mismatch_q     <= mismatch_d;
      mismatch_idx_q <= mismatch_idx_d;
      overflow_q     <= overflow_d;
      token_count_q  <= token_count_d;
      cycle_count_q  <= cycle_count_d;
      armed_q        <= armed_d;
    end
  end

  assign done         = done_q;
  assign mismatch     = mismatch_q;
  assign mismatch_idx = mismatch_idx_q;
  assign overflow     = overflow_q;
  assign token_count  = token_count_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_stream_token_sink.sv
// Directed bench for stream_token_sink (DEPTH=64 main instance, DEPTH=4 overflow instance).
module tb_stream_token_sink;
  import sparse_token_pkg::*;

  localparam int unsigned AW  = 6;
  localparam int unsigned SAW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, clk_en, flush, tile_en, start;
  logic               exp_wr_en;
  logic [AW-1:0]      exp_wr_addr;
  logic [TOKEN_W-1:0] exp_wr_data, data_in;
  logic               data_in_valid, data_in_ready;
  logic               done, mismatch, overflow;
  logic [AW-1:0]      mismatch_idx;
  logic [AW:0]        token_count;
  logic [31:0]        cycle_count;

  logic               s_start, s_exp_wr_en;
  logic [SAW-1:0]     s_exp_wr_addr;
  logic [TOKEN_W-1:0] s_exp_wr_data, s_data_in;
  logic               s_data_in_valid, s_data_in_ready;
  logic               s_done, s_mismatch, s_overflow;
  logic [SAW-1:0]     s_mismatch_idx;
  logic [SAW:0]       s_token_count;
  logic [31:0]        s_cycle_count;

  stream_token_sink #(.DEPTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .start(start), .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr),
    .exp_wr_data(exp_wr_data), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .done(done), .mismatch(mismatch),
    .mismatch_idx(mismatch_idx), .overflow(overflow), .token_count(token_count),
    .cycle_count(cycle_count)
  );

  stream_token_sink #(.DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .start(s_start), .exp_wr_en(s_exp_wr_en), .exp_wr_addr(s_exp_wr_addr),
    .exp_wr_data(s_exp_wr_data), .data_in(s_data_in), .data_in_valid(s_data_in_valid),
    .data_in_ready(s_data_in_ready), .done(s_done), .mismatch(s_mismatch),
    .mismatch_idx(s_mismatch_idx), .overflow(s_overflow), .token_count(s_token_count),
    .cycle_count(s_cycle_count)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  logic        m_run;
  token_t      tx [8];
  int          cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Golden ready: RUN and enabled, plus the LFSR stall pattern when built with stalls
  function automatic logic model_ready();
`ifdef STREAM_SINK_STALL_EN
    return m_run && clk_en && tile_en && ((m_lfsr & 16'h0003) != 16'h0000);
`else
    return m_run && clk_en && tile_en;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    if (m_run && clk_en) m_lfsr = lfsr_next(m_lfsr);
    @(negedge clk);
  endtask

  task automatic set_tx(input token_t a, input token_t b, input token_t c,
                        input token_t d, input token_t e);
    tx[0] = a; tx[1] = b; tx[2] = c; tx[3] = d; tx[4] = e;
  endtask

  task automatic load_ram(input int n);
    for (int k = 0; k < n; k++) begin
      exp_wr_en   = 1'b1;
      exp_wr_addr = AW'(k);
      exp_wr_data = tx[k];
      tick();
    end
    exp_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_run = 1'b1;
  endtask

  // Stream tx[0..n-1], holding each token until the model says it is taken
  task automatic send(input int n, input int pause_at, input int pause_len, output int cycles);
    int   i;
    int   guard;
    logic rdy;
    i = 0; cycles = 0; guard = 0;
    while (i < n && guard < 400) begin
      data_in       = tx[i];
      data_in_valid = 1'b1;
      if (i == pause_at && pause_len > 0) begin
        clk_en = 1'b0;
        #1;
        for (int k = 0; k < pause_len; k++) begin
          check("pause_ready", 32'(data_in_ready), 32'd0);
          tick();
          check("pause_tc", 32'(token_count), 32'(i));
          check("pause_cyc", cycle_count, 32'(cycles));
        end
        clk_en   = 1'b1;
        pause_at = -1;
      end
      #1;
      rdy = model_ready();
      check("ready", 32'(data_in_ready), 32'(rdy));
      cycles++;
      tick();
      if (rdy) i++;
      guard++;
    end
    data_in_valid = 1'b0;
    check("send_len", 32'(i), 32'(n));
    if (i == n && is_done(tx[n-1])) m_run = 1'b0;
  endtask

  task automatic check_clean_run(input string tag, input int cycles);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_tc"}, 32'(token_count), 32'd5);
    check({tag, "_cyc"}, cycle_count, 32'(cycles));
`ifdef STREAM_SINK_STALL_EN
    check({tag, "_cyc_gt5"}, 32'(cycle_count > 32'd5), 32'd1);
`else
    check({tag, "_cyc5"}, cycle_count, 32'd5);
`endif
    #1;
    check({tag, "_ready_after"}, 32'(data_in_ready), 32'd0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1; start = 1'b0;
    exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0; data_in = '0; data_in_valid = 1'b0;
    s_start = 1'b0; s_exp_wr_en = 1'b0; s_exp_wr_addr = '0; s_exp_wr_data = '0;
    s_data_in = '0; s_data_in_valid = 1'b0;
    m_lfsr = 16'hACE1; m_run = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", 32'(data_in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_idx", 32'(mismatch_idx), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tc", 32'(token_count), 32'd0);
    check("rst_cyc", cycle_count, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: clean run with DONE terminator
    set_tx(17'h00000, 17'h00001, 17'h00002, 17'h10000, DONE_TOKEN);
    load_ram(5);
    pulse_start();
    send(5, -1, 0, cyc);
    check_clean_run("t1", cyc);

    // Write while DONE must not reach the RAM
    exp_wr_en = 1'b1; exp_wr_addr = '0; exp_wr_data = 17'h1FFFF;
    tick();
    exp_wr_en = 1'b0;

    // 2: third token corrupted
    set_tx(17'h00000, 17'h00001, 17'h00007, 17'h10000, DONE_TOKEN);
    pulse_start();
    send(5, -1, 0, cyc);
    check("t2_mismatch", 32'(mismatch), 32'd1);
    check("t2_idx", 32'(mismatch_idx), 32'd2);
    check("t2_done", 32'(done), 32'd1);
    check("t2_tc", 32'(token_count), 32'd5);

    // 3: DEPTH=4 instance overflows after four data tokens
    for (int k = 0; k < 4; k++) begin
      s_exp_wr_en = 1'b1; s_exp_wr_addr = SAW'(k); s_exp_wr_data = 17'(k + 5);
      tick();
    end
    s_exp_wr_en = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    begin
      int i;
      i = 0; guard = 0;
      while (i < 4 && guard < 400) begin
        s_data_in = 17'(i + 5); s_data_in_valid = 1'b1;
        #1;
        if (s_data_in_ready) i++;
        tick();
        guard++;
      end
      check("t3_sent", 32'(i), 32'd4);
    end
    #1;
    check("t3_overflow", 32'(s_overflow), 32'd1);
    check("t3_done", 32'(s_done), 32'd1);
    check("t3_tc", 32'(s_token_count), 32'd4);
    check("t3_ready", 32'(s_data_in_ready), 32'd0);
    check("t3_mismatch", 32'(s_mismatch), 32'd0);
    s_data_in_valid = 1'b0;

    // 4: flush mid-run, tile_en gating, then clean replay of run 1
    set_tx(17'h00000, 17'h00001, 17'h00002, 17'h10000, DONE_TOKEN);
    pulse_start();
    send(2, -1, 0, cyc);
    check("t4_tc_pre", 32'(token_count), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_run = 1'b0;
    #1;
    check("t4_ready", 32'(data_in_ready), 32'd0);
    check("t4_tc", 32'(token_count), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_mismatch", 32'(mismatch), 32'd0);
    tile_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; tile_en = 1'b1;
    #1;
    check("t4_tile_idle", 32'(data_in_ready), 32'd0);
    tick();
    pulse_start();
    send(5, -1, 0, cyc);
    check_clean_run("t4r", cyc);

    // 6: clk_en low for three cycles mid-run
    pulse_start();
    send(5, 2, 3, cyc);
    check_clean_run("t6", cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
